// File: rtl/udp_loop_buf_if.sv
// Payload-side bus between the UDP core and the loopback buffer.
// master = UDP core side, slave = udp_loop_buf.
interface udp_loop_buf_if;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_data_en;
  logic        udp_tx_data_en;
  logic        udp_tx_done;
  logic        udp_tx_start;
  logic [7:0]  udp_tx_data;
  logic [15:0] ip_data_len;
  logic        busy;

  modport master (
    output udp_rx_data, udp_rx_data_en, udp_tx_data_en, udp_tx_done,
    input  udp_tx_start, udp_tx_data, ip_data_len, busy
  );

  modport slave (
    input  udp_rx_data, udp_rx_data_en, udp_tx_data_en, udp_tx_done,
    output udp_tx_start, udp_tx_data, ip_data_len, busy
  );
endinterface

// File: rtl/udp_loop_buf.sv
// Single-frame UDP payload loopback buffer: capture, close on idle gap, replay.
// Optional frame/drop counters when UDP_LOOP_STATS_EN is defined.
module udp_loop_buf #(
  parameter int ADDR_W   = 11,
  parameter int MIN_LEN  = 18,
  parameter int IDLE_GAP = 16
) (
  input  logic        gmii_txc,
  input  logic        rst_n,
`ifdef UDP_LOOP_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
`endif
  udp_loop_buf_if.slave bus
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);
  localparam logic [15:0]     MIN16   = 16'(MIN_LEN);
  localparam logic [7:0]      GAP_END = 8'(IDLE_GAP);

  typedef enum logic [2:0] {IDLE, FILL, START, SEND, DRAIN} state_t;

  state_t          state_q;
  logic [ADDR_W:0] wr_cnt_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic [7:0]      gap_q;
  logic            tx_start_q;
  logic [15:0]     len_q;
  logic            busy_q;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        ram_q;
  logic              rd_vld_q;
  logic              pad_q;
  logic [7:0]        hold_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              full;
  logic              close;
  logic              rd_req;
  logic              rd_ok;
  logic [15:0]       wr_len;
  logic [7:0]        rd_byte;

  assign full    = wr_cnt_q[ADDR_W];
  assign wr_len  = 16'(wr_cnt_q);
  assign close   = (state_q == FILL) && !bus.udp_rx_data_en && ((gap_q + 8'd1) == GAP_END);
  assign rd_req  = (state_q == SEND) && bus.udp_tx_data_en;
  assign rd_ok   = rd_req && (rd_ptr_q < wr_cnt_q);

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    if (bus.udp_rx_data_en) begin
      if (state_q == IDLE) begin
        we = 1'b1;
      end else if (state_q == FILL && !full) begin
        we    = 1'b1;
        waddr = wr_cnt_q[ADDR_W-1:0];
      end
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge gmii_txc) begin
    if (we)    mem[waddr] <= bus.udp_rx_data;
    if (rd_ok) ram_q      <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  // Read data path: the RAM register is only exposed in the cycle after a request;
  // padding forces zero, otherwise the last presented byte is held.
  assign rd_byte = pad_q ? 8'h00 : ram_q;

  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      pad_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      rd_vld_q <= rd_req;
      pad_q    <= rd_req && !rd_ok;
      if (rd_vld_q) hold_q <= rd_byte;
    end
  end

  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      len_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.udp_rx_data_en) begin
            wr_cnt_q <= ONE;
            gap_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (bus.udp_rx_data_en) begin
            gap_q <= '0;
            if (!full) wr_cnt_q <= wr_cnt_q + ONE;
          end else if (close) begin
            len_q      <= (wr_len > MIN16) ? wr_len : MIN16;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        START: begin
          rd_ptr_q <= '0;
          state_q  <= SEND;
        end
        SEND: begin
          if (rd_ok)           rd_ptr_q <= rd_ptr_q + ONE;
          if (bus.udp_tx_done) state_q  <= DRAIN;
        end
        DRAIN: begin
          wr_cnt_q <= '0;
          rd_ptr_q <= '0;
          gap_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.udp_tx_start = tx_start_q;
  assign bus.udp_tx_data  = rd_vld_q ? rd_byte : hold_q;
  assign bus.ip_data_len  = len_q;
  assign bus.busy         = busy_q;

`ifdef UDP_LOOP_STATS_EN
  logic        rx_en_prev_q;
  logic        ovf_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        drop_evt;

  // A dropped payload is counted once, on its first byte seen while busy.
  assign drop_evt = ((state_q inside {START, SEND, DRAIN}) && bus.udp_rx_data_en && !rx_en_prev_q)
                  || (close && ovf_q);

  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) begin
      rx_en_prev_q <= 1'b0;
      ovf_q        <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      rx_en_prev_q <= bus.udp_rx_data_en;
      if (state_q == IDLE)                                    ovf_q <= 1'b0;
      else if (state_q == FILL && bus.udp_rx_data_en && full) ovf_q <= 1'b1;
      if (tx_start_q)                         frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_loop_buf.sv
// Scoreboard bench for udp_loop_buf: random payloads, reference model of captured
// frames, decoupled monitor comparing lengths at start and bytes on each read.
module tb_udp_loop_buf;
  localparam int ADDR_W   = 11;
  localparam int MIN_LEN  = 18;
  localparam int IDLE_GAP = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  typedef byte unsigned bq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_loop_buf_if bus();

`ifdef UDP_LOOP_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  udp_loop_buf #(.ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN), .IDLE_GAP(IDLE_GAP)) dut (
    .gmii_txc (clk),
    .rst_n    (rst_n),
`ifdef UDP_LOOP_STATS_EN
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt),
`endif
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];
  int unsigned  len_q[$];
  bq_t          cur;
  int unsigned  cur_len;
  int start_cnt  = 0;
  int served     = 0;
  int exp_frames = 0;
  int exp_drops  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t rnd_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // ---------------- monitor ----------------
  logic req_at_edge = 1'b0;
  logic start_prev  = 1'b0;
  always @(posedge clk) req_at_edge <= bus.udp_tx_data_en;

  always @(negedge clk) begin
    if (req_at_edge) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_data: got 0x%0h with no expected byte queued", bus.udp_tx_data);
      end else begin
        check("tx_data", bus.udp_tx_data, exp_q.pop_front());
      end
    end
    if (bus.udp_tx_start) begin
      start_cnt++;
      if (start_prev) begin
        checks++; errors++;
        $display("FAIL start_width: got start high 2 cycles, required 1");
      end else if (len_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start: got start with len 0x%0h, required none", bus.ip_data_len);
      end else begin
        check("ip_data_len", bus.ip_data_len, len_q.pop_front());
      end
    end
    start_prev = bus.udp_tx_start;
  end

  // ---------------- reference model ----------------
  // A hole of IDLE_GAP or more closes the frame; later bytes arrive while busy and are lost.
  task automatic expect_frame(input bq_t data, input int hole_at, input int hole_len);
    bq_t cap = data;
    if (hole_len >= IDLE_GAP && hole_at > 0 && hole_at < data.size()) begin
      cap = data[0:hole_at-1];
      exp_drops++;
    end
    if (cap.size() > DEPTH) begin
      cap = cap[0:DEPTH-1];
      exp_drops++;
    end
    cur     = cap;
    cur_len = (cap.size() > MIN_LEN) ? cap.size() : MIN_LEN;
    len_q.push_back(cur_len);
    exp_frames++;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bq_t data, input int hole_at, input int hole_len);
    for (int i = 0; i < data.size(); i++) begin
      if (i == hole_at) repeat (hole_len) begin
        @(posedge clk); #1; bus.udp_rx_data_en = 1'b0;
      end
      @(posedge clk); #1;
      bus.udp_rx_data_en = 1'b1;
      bus.udp_rx_data    = data[i];
    end
    @(posedge clk); #1;
    bus.udp_rx_data_en = 1'b0;
  endtask

  task automatic transmit(input int nreads, input bit do_done);
    int  w = 0;
    bit  last_done = 1'($urandom);
    do begin @(posedge clk); w++; end while (start_cnt <= served && w < 5000);
    if (start_cnt <= served) begin
      checks++; errors++;
      $display("FAIL start_timeout: got no start in %0d cycles, required one", w);
      return;
    end
    served++;
    #1;
    for (int i = 0; i < nreads; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.udp_tx_data_en = 1'b0; @(posedge clk); #1;
      end
      bus.udp_tx_data_en = 1'b1;
      exp_q.push_back((i < cur.size()) ? cur[i] : 8'h00);
      if (do_done && last_done && i == nreads - 1) bus.udp_tx_done = 1'b1;
      @(posedge clk); #1;
    end
    bus.udp_tx_data_en = 1'b0;
    bus.udp_tx_done    = 1'b0;
    if (do_done) begin
      if (!last_done) begin
        bus.udp_tx_done = 1'b1; @(posedge clk); #1; bus.udp_tx_done = 1'b0;
      end
      check("len_hold", bus.ip_data_len, cur_len);
      @(posedge clk); @(negedge clk);
      check("busy_after_done", bus.busy, 0);
    end
  endtask

  task automatic frame(input bq_t d, input int hole_at, input int hole_len, input int extra);
    expect_frame(d, hole_at, hole_len);
    drive(d, hole_at, hole_len);
    transmit(cur_len + extra, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bq_t d;
    int  k;
    int  s0;
    bus.udp_rx_data    = '0;
    bus.udp_rx_data_en = 1'b0;
    bus.udp_tx_data_en = 1'b0;
    bus.udp_tx_done    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", bus.udp_tx_start, 0);
    check("rst_tx_data",  bus.udp_tx_data,  0);
    check("rst_len",      bus.ip_data_len,  0);
    check("rst_busy",     bus.busy,         0);
    rst_n = 1'b1;

    // Incrementing 32-byte payload; measure the idle gap before start.
    d = {};
    for (int i = 0; i < 32; i++) d.push_back(8'(i));
    expect_frame(d, -1, 0);
    drive(d, -1, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.udp_tx_start && k < 200);
    check("start_idle_cycles", k - 1, IDLE_GAP);
    transmit(32, 1'b1);

    // Short payload padded to MIN_LEN, plus over-read.
    d = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    frame(d, -1, 0, 2);

    // Holes just under and exactly at the gap.
    d = rnd_bytes(30);
    frame(d, 10, IDLE_GAP - 1, $urandom_range(0, 3));
    d = rnd_bytes(30);
    frame(d, 10, IDLE_GAP, $urandom_range(0, 3));

    // Overflow: truncation at DEPTH, byte 0 intact.
    d = rnd_bytes(2100);
    frame(d, -1, 0, 1);

    // Payload injected during SEND is dropped.
    d = rnd_bytes(20);
    expect_frame(d, -1, 0);
    drive(d, -1, 0);
    s0 = served;
    fork
      transmit(cur_len, 1'b1);
      begin
        k = 0;
        while (served == s0 && k < 6000) begin @(posedge clk); k++; end
        repeat (3) @(posedge clk);
        exp_drops++;
        drive(rnd_bytes(6), -1, 0);
      end
    join

    for (int n = 0; n < 3; n++) begin
      d = rnd_bytes($urandom_range(1, 60));
      frame(d, $urandom_range(1, 8), $urandom_range(0, IDLE_GAP - 1), $urandom_range(0, 3));
    end

`ifdef UDP_LOOP_STATS_EN
    check("frame_cnt", frame_cnt, exp_frames);
    check("drop_cnt",  drop_cnt,  exp_drops);
`endif

    // Asynchronous reset in the middle of SEND.
    d = rnd_bytes(24);
    expect_frame(d, -1, 0);
    drive(d, -1, 0);
    transmit(5, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_tx_start", bus.udp_tx_start, 0);
    check("async_tx_data",  bus.udp_tx_data,  0);
    check("async_len",      bus.ip_data_len,  0);
    check("async_busy",     bus.busy,         0);
    exp_frames = 0;
    exp_drops  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    d = rnd_bytes(20);
    frame(d, -1, 0, $urandom_range(0, 3));

    repeat (5) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("len_q_empty", len_q.size(), 0);
`ifdef UDP_LOOP_STATS_EN
    check("frame_cnt_end", frame_cnt, exp_frames);
    check("drop_cnt_end",  drop_cnt,  exp_drops);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
